video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Raster timing stage directly upstream of the snake pixel painter.
//  - Generates 1280x720@60 sync/blank timing from pixel_clk.
//  - Issues pixel_xpos/pixel_ypos one cycle before display so the painter's registered pixel_data lands on video_de.
//  - Gates that pixel_data onto video_rgb for the HDMI encoder.
// PARAMETERS
//  H_SYNC   40    hsync width (clk)       | V_SYNC   5    vsync width (lines)
//  H_BACK   220   h back porch            | V_BACK   20   v back porch
//  H_DISP   1280  active pixels/line      | V_DISP   720  active lines
//  H_FRONT  110   h front porch           | V_FRONT  5    v front porch
//  SYNC_POL 1     sync active level (1 = active-high)
//  H_TOTAL = sum of H_* (1650); V_TOTAL = sum of V_* (750); derived localparams
// PORTS
//  pixel_clk    in   1   pixel clock, 74.25 MHz
//  sys_rst      in   1   async reset, active-high
//  pixel_data   in   24  RGB888 from painter, registered 1 clk after xpos/ypos
//  pattern_sel  in   1   colour-bar select (used only with VIDEO_PATTERN_EN)
//  pixel_xpos   out  11  requested column 0..H_DISP-1; 0 when data_req=0
//  pixel_ypos   out  11  requested row 0..V_DISP-1; 0 when data_req=0
//  data_req     out  1   pixel request, leads video_de by exactly 1 clk
//  video_hs     out  1   horizontal sync
//  video_vs     out  1   vertical sync
//  video_de     out  1   active-video enable
//  video_rgb    out  24  pixel to encoder; 0 when video_de=0
//  frame_start  out  1   1-clk pulse at h_cnt=0,v_cnt=0
// BEHAVIOUR
//  Counters:
//  - h_cnt 0..H_TOTAL-1, wraps to 0.
//  - v_cnt increments only on the h_cnt wrap cycle; wraps V_TOTAL-1 -> 0 on the same edge.
//  Line/frame order: sync, back porch, display, front porch (H and V alike).
//  Derived regions (HA = H_SYNC+H_BACK, VA = V_SYNC+V_BACK):
//  - hs active: h_cnt < H_SYNC.   vs active: v_cnt < V_SYNC.
//  - video_de: h_cnt in [HA, HA+H_DISP) and v_cnt in [VA, VA+V_DISP).
//  - data_req: h_cnt in [HA-1, HA+H_DISP-1), same v window.
//  - pixel_xpos = h_cnt-(HA-1); pixel_ypos = v_cnt-VA; 11-bit unsigned.
//  Latency:
//  - Sample k: xpos=k at clk t, video_de/video_rgb for k at clk t+1.
//  - video_rgb = video_de ? pixel_data : 0; no further pipelining.
//  - data_req, xpos, ypos, hs, vs, de, frame_start decode combinationally from h_cnt/v_cnt, gated by sys_rst.
//  Reset (async, sys_rst=1):
//  - h_cnt=v_cnt=0; hs/vs at inactive level (!SYNC_POL).
//  - data_req=0, video_de=0, xpos=ypos=0, video_rgb=0, frame_start=0.
//  - Reset mid-frame aborts the line immediately; after release timing restarts at h_cnt=0,v_cnt=0.
//  - frame_start fires on the first clk after release.
//  Boundaries:
//  - Last active pixel: h_cnt=HA+H_DISP-1; data_req already 0 there.
//  - Line wrap and frame wrap may coincide; both counters update on the same edge.
//  - V blanking suppresses data_req/de for the whole line, including the H window.
//  - pixel_data is ignored whenever video_de=0.
// CONFIGURATION
//  VIDEO_PATTERN_EN defined:
//  - pattern_sel=1 replaces pixel_data with 8 vertical bars, each H_DISP/8 wide.
//  - Bar order: white, yellow, cyan, green, magenta, red, blue, black.
//  - Bars are indexed by xpos of the request cycle, so they keep the 1-clk alignment.
//  - pattern_sel is sampled per pixel.
//  VIDEO_PATTERN_EN undefined: pattern_sel ignored, no bar logic synthesised.
// TESTING
//  1 Release reset, run 2 frames -> hs period 1650 clk, high 40; vs period 1237500 clk, high 5 lines; frame_start every 1237500 clk.
//  2 Count de per line/frame -> exactly 1280 clk per active line, 720 active lines, first de at h_cnt=260,v_cnt=25.
//  3 Painter model pixel_data={xpos,ypos} registered -> video_rgb on each de cycle holds xpos of the previous clk; 0 when de=0.
//  4 Assert sys_rst at h_cnt=800,v_cnt=300 for 3 clk -> outputs take reset values immediately; frame_start 1 clk after release.
//  5 Check h_cnt=1649,v_cnt=749 -> next clk h_cnt=0,v_cnt=0, hs and vs both go active.
//  6 VIDEO_PATTERN_EN, pattern_sel=1 -> x=0..159 gives 24'hFFFFFF; x=160 gives 24'hFFFF00; x=1279 gives 24'h000000.

Source files
------------

// File: rtl/video_timing_gen.sv
// 1280x720@60 raster timing with one-cycle-early pixel request and RGB gating.
// Optional colour bars on pattern_sel when VIDEO_PATTERN_EN is defined.
module video_timing_gen #(
    parameter int H_SYNC   = 40,
    parameter int H_BACK   = 220,
    parameter int H_DISP   = 1280,
    parameter int H_FRONT  = 110,
    parameter int V_SYNC   = 5,
    parameter int V_BACK   = 20,
    parameter int V_DISP   = 720,
    parameter int V_FRONT  = 5,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic        pixel_clk,
    input  logic        sys_rst,
    input  logic [23:0] pixel_data,
    input  logic        pattern_sel,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic        data_req,
    output logic        video_hs,
    output logic        video_vs,
    output logic        video_de,
    output logic [23:0] video_rgb,
    output logic        frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int HA      = H_SYNC + H_BACK;
    localparam int VA      = V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_SYNC_E  = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_E  = 11'(V_SYNC);
    localparam logic [10:0] H_REQ_B   = 11'(HA - 1);
    localparam logic [10:0] H_REQ_E   = 11'(HA + H_DISP - 1);
    localparam logic [10:0] H_DE_B    = 11'(HA);
    localparam logic [10:0] H_DE_E    = 11'(HA + H_DISP);
    localparam logic [10:0] V_ACT_B   = 11'(VA);
    localparam logic [10:0] V_ACT_E   = 11'(VA + V_DISP);

    logic [10:0] r_h_cnt;
    logic [10:0] r_v_cnt;
    logic        w_h_req;
    logic        w_h_de;
    logic        w_v_act;
    logic [23:0] w_src_rgb;

    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 11'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 11'd1;
        end
    end

    assign w_h_req = (r_h_cnt >= H_REQ_B) && (r_h_cnt < H_REQ_E);
    assign w_h_de  = (r_h_cnt >= H_DE_B) && (r_h_cnt < H_DE_E);
    assign w_v_act = (r_v_cnt >= V_ACT_B) && (r_v_cnt < V_ACT_E);

    assign data_req    = ~sys_rst & w_h_req & w_v_act;
    assign video_de    = ~sys_rst & w_h_de & w_v_act;
    assign pixel_xpos  = data_req ? (r_h_cnt - H_REQ_B) : '0;
    assign pixel_ypos  = data_req ? (r_v_cnt - V_ACT_B) : '0;
    assign video_hs    = (~sys_rst && (r_h_cnt < H_SYNC_E)) ? SYNC_POL : ~SYNC_POL;
    assign video_vs    = (~sys_rst && (r_v_cnt < V_SYNC_E)) ? SYNC_POL : ~SYNC_POL;
    assign frame_start = ~sys_rst && (r_h_cnt == '0) && (r_v_cnt == '0);

`ifdef VIDEO_PATTERN_EN
    localparam logic [10:0] BAR_W = 11'(H_DISP / 8);

    logic [2:0]  w_bar_idx;
    logic [23:0] w_bar_rgb;
    logic [23:0] r_bar_rgb;
    logic        r_pat_sel;

    assign w_bar_idx = 3'(pixel_xpos / BAR_W);

    always_comb begin
        w_bar_rgb = 24'h000000;
        case (w_bar_idx)
            3'd0:    w_bar_rgb = 24'hFFFFFF;
            3'd1:    w_bar_rgb = 24'hFFFF00;
            3'd2:    w_bar_rgb = 24'h00FFFF;
            3'd3:    w_bar_rgb = 24'h00FF00;
            3'd4:    w_bar_rgb = 24'hFF00FF;
            3'd5:    w_bar_rgb = 24'hFF0000;
            3'd6:    w_bar_rgb = 24'h0000FF;
            default: w_bar_rgb = 24'h000000;
        endcase
    end

    // Bar colour and select ride alongside the painter's registered data.
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_bar_rgb <= '0;
            r_pat_sel <= 1'b0;
        end else begin
            r_bar_rgb <= w_bar_rgb;
            r_pat_sel <= pattern_sel;
        end
    end

    assign w_src_rgb = r_pat_sel ? r_bar_rgb : pixel_data;
`else
    logic w_unused_sel;
    assign w_unused_sel = pattern_sel;
    assign w_src_rgb    = pixel_data;
`endif

    assign video_rgb = video_de ? w_src_rgb : '0;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: full-size instance over the first active lines,
// reduced-size instance over several whole frames with a mid-frame reset.
module tb_video_timing_gen;

    localparam int S_HS = 4, S_HB = 6, S_HD = 16, S_HF = 3;
    localparam int S_VS = 2, S_VB = 3, S_VD = 8, S_VF = 2;
    localparam int S_HT = S_HS + S_HB + S_HD + S_HF;
    localparam int S_VT = S_VS + S_VB + S_VD + S_VF;
    localparam int S_HA = S_HS + S_HB;
    localparam int S_VA = S_VS + S_VB;
    localparam int S_FR = S_HT * S_VT;

    int n_chk  = 0;
    int n_pass = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_d, psel_d;
    logic [23:0] pd_d, rgb_d;
    logic [10:0] x_d, y_d;
    logic        req_d, hs_d, vs_d, de_d, fs_d;

    logic        rst_s, psel_s;
    logic [23:0] pd_s, rgb_s;
    logic [10:0] x_s, y_s;
    logic        req_s, hs_s, vs_s, de_s, fs_s;

    video_timing_gen u_dut (
        .pixel_clk  (clk),
        .sys_rst    (rst_d),
        .pixel_data (pd_d),
        .pattern_sel(psel_d),
        .pixel_xpos (x_d),
        .pixel_ypos (y_d),
        .data_req   (req_d),
        .video_hs   (hs_d),
        .video_vs   (vs_d),
        .video_de   (de_d),
        .video_rgb  (rgb_d),
        .frame_start(fs_d)
    );

    video_timing_gen #(
        .H_SYNC(S_HS), .H_BACK(S_HB), .H_DISP(S_HD), .H_FRONT(S_HF),
        .V_SYNC(S_VS), .V_BACK(S_VB), .V_DISP(S_VD), .V_FRONT(S_VF)
    ) u_small (
        .pixel_clk  (clk),
        .sys_rst    (rst_s),
        .pixel_data (pd_s),
        .pattern_sel(psel_s),
        .pixel_xpos (x_s),
        .pixel_ypos (y_s),
        .data_req   (req_s),
        .video_hs   (hs_s),
        .video_vs   (vs_s),
        .video_de   (de_s),
        .video_rgb  (rgb_s),
        .frame_start(fs_s)
    );

    // Painter models: register the requested coordinates
    always @(posedge clk) pd_d <= {2'b00, x_d, y_d};
    always @(posedge clk) pd_s <= {2'b00, x_s, y_s};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

`ifdef VIDEO_PATTERN_EN
    function automatic logic [23:0] bar_rgb(input int x, input int w);
        case (x / w)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction
`endif

    // Reference raster position for the small instance
    int   mh = 0, mv = 0;
    logic psel_q = 1'b0;
    always @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            mh <= 0;
            mv <= 0;
        end else if (mh == S_HT - 1) begin
            mh <= 0;
            mv <= (mv == S_VT - 1) ? 0 : mv + 1;
        end else begin
            mh <= mh + 1;
        end
    end
    always @(posedge clk) psel_q <= psel_s;

    logic s_run = 1'b0;
    int   wrap_seen = 0;
    logic was_last = 1'b0;

    always begin
        logic        e_req, e_de, e_hs, e_vs, e_fs, act;
        logic [10:0] e_x, e_y;
        logic [23:0] e_rgb;
        @(negedge clk);
        #2;
        if (s_run) begin
            act   = !rst_s;
            e_hs  = act && (mh < S_HS);
            e_vs  = act && (mv < S_VS);
            e_fs  = act && (mh == 0) && (mv == 0);
            e_req = act && (mh >= S_HA - 1) && (mh < S_HA + S_HD - 1)
                        && (mv >= S_VA) && (mv < S_VA + S_VD);
            e_de  = act && (mh >= S_HA) && (mh < S_HA + S_HD)
                        && (mv >= S_VA) && (mv < S_VA + S_VD);
            e_x   = e_req ? 11'(mh - (S_HA - 1)) : 11'd0;
            e_y   = e_req ? 11'(mv - S_VA) : 11'd0;
            e_rgb = {2'b00, 11'(mh - S_HA), 11'(mv - S_VA)};
`ifdef VIDEO_PATTERN_EN
            if (psel_q) e_rgb = bar_rgb(mh - S_HA, S_HD / 8);
`endif
            if (!e_de) e_rgb = '0;
            chk("s_hs", hs_s, e_hs);
            chk("s_vs", vs_s, e_vs);
            chk("s_fs", fs_s, e_fs);
            chk("s_req", req_s, e_req);
            chk("s_de", de_s, e_de);
            chk("s_xpos", x_s, e_x);
            chk("s_ypos", y_s, e_y);
            chk("s_rgb", rgb_s, e_rgb);
            if (was_last && e_fs) wrap_seen++;
            was_last = act && (mh == S_HT - 1) && (mv == S_VT - 1);
        end
    end

    task automatic step_s(input int n);
        repeat (n) begin
            @(negedge clk);
            psel_s = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic run_small();
        logic found;
        rst_s  = 1'b1;
        psel_s = 1'b0;
        s_run  = 1'b1;
        repeat (2) @(negedge clk);
        rst_s = 1'b0;
        step_s(3 * S_FR + 10);
        found = 1'b0;
        for (int i = 0; i < 2 * S_FR && !found; i++) begin
            @(negedge clk);
            #3;
            if (mh == 15 && mv == 7) found = 1'b1;
        end
        chk("s_find_mid", found, 1'b1);
        rst_s = 1'b1;
        #1;
        chk("s_rst_de", de_s, 1'b0);
        chk("s_rst_req", req_s, 1'b0);
        chk("s_rst_x", x_s, 11'd0);
        chk("s_rst_rgb", rgb_s, 24'd0);
        chk("s_rst_hs", hs_s, 1'b0);
        chk("s_rst_vs", vs_s, 1'b0);
        chk("s_rst_fs", fs_s, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_s = 1'b0;
        #1;
        chk("s_rel_fs", fs_s, 1'b1);
        chk("s_rel_hs", hs_s, 1'b1);
        chk("s_rel_vs", vs_s, 1'b1);
        @(negedge clk);
        #1;
        chk("s_rel_fs_pulse", fs_s, 1'b0);
        step_s(2 * S_FR + 10);
        s_run = 1'b0;
        chk("s_wrap_seen", wrap_seen >= 4, 1'b1);
    endtask

    task automatic run_full();
        int   h, v, x;
        int   hs_rise0, hs_rise1, hs_hi, vs_hi, fs_cnt;
        int   de_first, req_first, de_line;
        logic prev_hs;
        logic [23:0] e;
        hs_rise0 = -1; hs_rise1 = -1; hs_hi = 0; vs_hi = 0; fs_cnt = 0;
        de_first = -1; req_first = -1; de_line = 0;
        rst_d  = 1'b1;
        psel_d = 1'b0;
        repeat (3) @(negedge clk);
        chk("d_rst_de", de_d, 1'b0);
        chk("d_rst_req", req_d, 1'b0);
        chk("d_rst_hs", hs_d, 1'b0);
        chk("d_rst_vs", vs_d, 1'b0);
        chk("d_rst_fs", fs_d, 1'b0);
        chk("d_rst_rgb", rgb_d, 24'd0);
        prev_hs = hs_d;
        rst_d = 1'b0;
        #1;
        for (int t = 0; t < 26 * 1650 + 1545; t++) begin
            h = t % 1650;
            v = t / 1650;
            if (hs_d && !prev_hs) begin
                if (hs_rise0 < 0) hs_rise0 = t;
                else if (hs_rise1 < 0) hs_rise1 = t;
            end
            prev_hs = hs_d;
            if (v == 0 && hs_d) hs_hi++;
            if (vs_d) vs_hi++;
            if (fs_d) fs_cnt++;
            if (de_d && de_first < 0) de_first = t;
            if (req_d && req_first < 0) req_first = t;
            if (v == 25 && de_d) de_line++;
            if (v == 25 && de_d)
                chk("d_rgb", rgb_d, {2'b00, 11'(h - 260), 11'd0});
            if (v >= 24 && !de_d) chk("d_rgb_gate", rgb_d, 24'd0);
            if (v == 25 && h == 259) chk("d_x_first", x_d, 11'd0);
            if (v == 25 && h == 1538) chk("d_x_last", x_d, 11'd1279);
            if (v == 25 && h == 1539) begin
                chk("d_req_lastpix", req_d, 1'b0);
                chk("d_de_lastpix", de_d, 1'b1);
            end
            if (v == 25 && h == 1540) chk("d_de_end", de_d, 1'b0);
            if (v == 24 && h == 600) chk("d_vblank_req", req_d, 1'b0);
            x = h - 260;
            if (v == 26 && de_d && (x == 0 || x == 159 || x == 160 || x == 1279)) begin
                e = {2'b00, 11'(x), 11'd1};
`ifdef VIDEO_PATTERN_EN
                e = bar_rgb(x, 160);
`endif
                chk("d_bar", rgb_d, e);
            end
            @(negedge clk);
            psel_d = (v == 26);
        end
        chk("d_hs_first", hs_rise0, 0);
        chk("d_hs_period", hs_rise1 - hs_rise0, 1650);
        chk("d_hs_high", hs_hi, 40);
        chk("d_vs_high", vs_hi, 5 * 1650);
        chk("d_fs_count", fs_cnt, 1);
        chk("d_de_first", de_first, 25 * 1650 + 260);
        chk("d_req_first", req_first, 25 * 1650 + 259);
        chk("d_de_line", de_line, 1280);
    endtask

    initial begin
        rst_d = 1'b1; rst_s = 1'b1;
        psel_d = 1'b0; psel_s = 1'b0;
        fork
            run_full();
            run_small();
        join
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
